// File: rtl/packed_word_pkg.sv
// Shared types for the packed-word path: field widths, packed word layout and serializer states.
package packed_word_pkg;
  localparam int LO_W_DEF = 8;
  localparam int HI_W_DEF = 4;

  typedef struct packed {
    logic [HI_W_DEF-1:0] hi;
    logic [LO_W_DEF-1:0] lo;
  } packed_word_t;

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Pointers carry an extra wrap bit so full/empty decode without a count.
module sync_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/packed_word_serializer.sv
// Buffers packed {hi, lo} words and re-emits each as a lo beat then a zero-extended hi beat.
module packed_word_serializer
  import packed_word_pkg::*;
#(
  parameter int LO_W  = LO_W_DEF,
  parameter int HI_W  = HI_W_DEF,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LO_W+HI_W-1:0] in_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LO_W-1:0]      out_data,
  output logic                 out_field,
  output logic                 out_last,
  output logic [CNT_W-1:0]     word_count
);
  localparam int W = LO_W + HI_W;

  state_t         state, state_nxt;
  logic [W-1:0]   hold, fifo_data;
  logic           pop, cnt_inc, full, empty;

  // in_ready looks only at full so the input handshake never waits on the FSM's pop.
  assign in_ready = !full;

  sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .wr_data (in_word),
    .pop     (pop),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      if (pop)     hold       <= fifo_data;
      if (cnt_inc) word_count <= word_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = SEND_LO;
      end
      SEND_LO: if (out_ready) state_nxt = SEND_HI;
      SEND_HI: if (out_ready) begin
        cnt_inc = 1'b1;
        // Chain straight into the next word so sustained rate stays at 2 beats per word.
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = SEND_LO;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode only from state and hold, so they are stable under backpressure.
  always_comb begin
    out_valid = (state != IDLE);
    out_field = (state == SEND_HI);
    out_last  = (state == SEND_HI);
    out_data  = '0;
    case (state)
      SEND_LO: out_data = hold[LO_W-1:0];
      SEND_HI: out_data = LO_W'(hold[W-1:LO_W]);
      default: out_data = '0;
    endcase
  end
endmodule

// File: tb/tb_packed_word_serializer.sv
// Directed bench for packed_word_serializer (CNT_W=4 so counter wrap is reachable).
module tb_packed_word_serializer;
  import packed_word_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_field, out_last;
  logic [11:0] in_word;
  logic [7:0]  out_data;
  logic [3:0]  word_count;
  int          checks = 0;
  int          failures = 0;
  packed_word_t pw;

  packed_word_serializer #(.LO_W(8), .HI_W(4), .DEPTH(2), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_field  (out_field),
    .out_last   (out_last),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] d, input logic f);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".field"}, 32'(out_field), 32'(f));
    chk({tag, ".last"},  32'(out_last),  32'(f));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_word = '0;
    tick(); tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data",  32'(out_data),  32'd0);
    chk("rst.count", 32'(word_count), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.idle",     32'(out_valid), 32'd0);

    // Single word A5C
    pw = '{hi: 4'hA, lo: 8'h5C};
    in_valid = 1'b1; in_word = pw; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single.lat0", 32'(out_valid), 32'd0);
    tick(); chk_beat("single.lo", 8'h5C, 1'b0);
    tick(); chk_beat("single.hi", 8'h0A, 1'b1);
    chk("single.cnt_mid", 32'(word_count), 32'd0);
    tick();
    chk("single.idle", 32'(out_valid), 32'd0);
    chk("single.cnt",  32'(word_count), 32'd1);

    // Backpressure: 3 words fill hold + FIFO, 4th refused
    out_ready = 1'b0;
    in_valid = 1'b1; in_word = 12'h123; tick();
    chk("bp.rdy1", 32'(in_ready), 32'd1);
    in_word = 12'h456; tick();
    chk("bp.rdy2", 32'(in_ready), 32'd1);
    in_word = 12'h789; tick();
    chk("bp.rdy3", 32'(in_ready), 32'd0);
    in_word = 12'hABC;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_beat("bp.stall", 8'h23, 1'b0);
      chk("bp.full", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); chk_beat("bp.w0hi", 8'h01, 1'b1);
    tick(); chk_beat("bp.w1lo", 8'h56, 1'b0);
    chk("bp.cnt2", 32'(word_count), 32'd2);
    chk("bp.rdy_after_pop", 32'(in_ready), 32'd1);
    tick(); chk_beat("bp.w1hi", 8'h04, 1'b1);
    tick(); chk_beat("bp.w2lo", 8'h89, 1'b0);
    tick(); chk_beat("bp.w2hi", 8'h07, 1'b1);
    tick();
    chk("bp.idle", 32'(out_valid), 32'd0);
    chk("bp.cnt4", 32'(word_count), 32'd4);

    // Back-to-back 111, 222, 333
    in_valid = 1'b1; in_word = 12'h111; tick();
    chk("b2b.lat0", 32'(out_valid), 32'd0);
    in_word = 12'h222; tick(); chk_beat("b2b.11", 8'h11, 1'b0);
    in_word = 12'h333; tick(); chk_beat("b2b.01", 8'h01, 1'b1);
    in_valid = 1'b0;
    chk("b2b.full", 32'(in_ready), 32'd0);
    tick(); chk_beat("b2b.22", 8'h22, 1'b0);
    tick(); chk_beat("b2b.02", 8'h02, 1'b1);
    tick(); chk_beat("b2b.33", 8'h33, 1'b0);
    tick(); chk_beat("b2b.03", 8'h03, 1'b1);
    tick();
    chk("b2b.idle", 32'(out_valid), 32'd0);
    chk("b2b.cnt7", 32'(word_count), 32'd7);

    // Full FIFO with input held valid while the sink drains
    out_ready = 1'b0;
    in_valid = 1'b1; in_word = 12'hA01; tick();
    in_word = 12'hA02; tick();
    in_word = 12'hA03; tick();
    chk("full.rdy0", 32'(in_ready), 32'd0);
    in_word = 12'hA04; out_ready = 1'b1;
    tick(); chk_beat("full.a01hi", 8'h0A, 1'b1);
    chk("full.rdy_still0", 32'(in_ready), 32'd0);
    tick(); chk_beat("full.a02lo", 8'h02, 1'b0);
    chk("full.rdy_after_pop", 32'(in_ready), 32'd1);
    chk("full.cnt8", 32'(word_count), 32'd8);
    tick(); chk_beat("full.a02hi", 8'h0A, 1'b1);
    chk("full.refull", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick(); chk_beat("full.a03lo", 8'h03, 1'b0);
    tick(); chk_beat("full.a03hi", 8'h0A, 1'b1);
    tick(); chk_beat("full.a04lo", 8'h04, 1'b0);
    tick(); chk_beat("full.a04hi", 8'h0A, 1'b1);
    tick();
    chk("full.idle", 32'(out_valid), 32'd0);
    chk("full.cnt11", 32'(word_count), 32'd11);

    // Reset during SEND_HI with two words queued
    out_ready = 1'b0;
    in_valid = 1'b1; in_word = 12'hB01; tick();
    in_word = 12'hB02; tick();
    in_word = 12'hB03; tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); chk_beat("mrst.pre", 8'h0B, 1'b1);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst.valid", 32'(out_valid), 32'd0);
    chk("mrst.count", 32'(word_count), 32'd0);
    chk("mrst.data",  32'(out_data),  32'd0);
    chk("mrst.field", 32'(out_field), 32'd0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst.nobeat", 32'(out_valid), 32'd0);
      chk("mrst.in_ready", 32'(in_ready), 32'd1);
    end

    // Counter wrap: 17 words through a 4-bit counter ends at 1
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1; in_word = 12'(k);
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("wrap.cnt", 32'(word_count), 32'((k + 1) % 16));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
